// File: rtl/fifo_mem_param.sv
// fifo_mem_param: parametrised single-clock FIFO with programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags,
// an occupancy count and a selectable standard or first-word-fall-through
// read port. Storage is a plain register array that is not reset.
module fifo_mem_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned AE_LEVEL = 2,
  parameter bit          FWFT     = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  input  logic              flag_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              fifo_almost_full,
  output logic              fifo_almost_empty,
  output logic              fifo_overflow,
  output logic              fifo_underflow,
  output logic [ADDR_W:0]   fifo_level
);

  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LVL_AF   = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] LVL_AE   = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] LVL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wr_ok, rd_ok;

  // Status flags decode straight from the registered level, so they move
  // on the same edge as the level itself.
  always_comb begin
    fifo_level        = level_q;
    fifo_full         = (level_q == LVL_FULL);
    fifo_empty        = (level_q == '0);
    fifo_almost_full  = (level_q >= LVL_AF);
    fifo_almost_empty = (level_q <= LVL_AE);
    fifo_overflow     = ovf_q;
    fifo_underflow    = unf_q;
  end

  // Request acceptance against the pre-edge full/empty state.
  always_comb begin
    wr_ok = wr & ~fifo_full;
    rd_ok = rd & ~fifo_empty;
  end

  // Next pointers, level and sticky error flags.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    // Pointers are exactly ADDR_W bits wide, so DEPTH-1 -> 0 wraps naturally.
    if (wr_ok) wptr_d = wptr_q + PTR_ONE;
    if (rd_ok) rptr_d = rptr_q + PTR_ONE;

    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    // A fresh error in the same cycle as flag_clr must survive the clear.
    if (flag_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (wr & fifo_full)  ovf_d = 1'b1;
    if (rd & fifo_empty) unf_d = 1'b1;
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem_q[wptr_q] <= data_in;
  end

  if (FWFT) begin : g_fwft
    // Head word is presented combinationally; a pop simply advances rptr.
    always_comb begin
      data_out = mem_q[rptr_q];
      rd_valid = ~fifo_empty;
    end
  end else begin : g_std
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              rv_q, rv_d;

    // Registered read: capture the head on an accepted pop, else hold.
    always_comb begin
      dout_d = dout_q;
      rv_d   = 1'b0;
      if (rd_ok) begin
        dout_d = mem_q[rptr_q];
        rv_d   = 1'b1;
      end
    end

    // Read data/valid register with synchronous reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q <= '0;
        rv_q   <= 1'b0;
      end else begin
        dout_q <= dout_d;
        rv_q   <= rv_d;
      end
    end

    always_comb begin
      data_out = dout_q;
      rd_valid = rv_q;
    end
  end

endmodule

// File: tb/tb_fifo_mem_param.sv
// Bench for fifo_mem_param: a standard-read and an FWFT instance share one
// stimulus stream and are compared each cycle against a queue-based model.
module tb_fifo_mem_param;

  logic       clk = 1'b0;
  logic       rst, wr, rd, flag_clr;
  logic [7:0] din;

  logic [7:0] dout_s, dout_f;
  logic       rv_s, full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
  logic       rv_f, full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
  logic [4:0] lvl_s, lvl_f;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q[$];
  bit         m_ovf, m_unf, m_rv;
  logic [7:0] m_dout;

  always #5 clk = ~clk;

  fifo_mem_param #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .AF_LEVEL(12),
                   .AE_LEVEL(2), .FWFT(1'b0)) dut_s (
    .clk(clk), .rst(rst), .wr(wr), .data_in(din), .rd(rd), .flag_clr(flag_clr),
    .data_out(dout_s), .rd_valid(rv_s), .fifo_full(full_s), .fifo_empty(empty_s),
    .fifo_almost_full(af_s), .fifo_almost_empty(ae_s), .fifo_overflow(ovf_s),
    .fifo_underflow(unf_s), .fifo_level(lvl_s));

  fifo_mem_param #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .AF_LEVEL(12),
                   .AE_LEVEL(2), .FWFT(1'b1)) dut_f (
    .clk(clk), .rst(rst), .wr(wr), .data_in(din), .rd(rd), .flag_clr(flag_clr),
    .data_out(dout_f), .rd_valid(rv_f), .fifo_full(full_f), .fifo_empty(empty_f),
    .fifo_almost_full(af_f), .fifo_almost_empty(ae_f), .fifo_overflow(ovf_f),
    .fifo_underflow(unf_f), .fifo_level(lvl_f));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare both instances.
  task automatic cyc(input bit r, input bit w, input logic [7:0] d,
                     input bit rr, input bit c);
    bit pre_full, pre_empty;
    int n;
    rst = r; wr = w; din = d; rd = rr; flag_clr = c;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_rv = 0; m_dout = 8'h00;
    end else begin
      pre_full  = (q.size() == 16);
      pre_empty = (q.size() == 0);
      m_rv = 0;
      if (c) begin m_ovf = 0; m_unf = 0; end
      if (w && pre_full)  m_ovf = 1;
      if (rr && pre_empty) m_unf = 1;
      if (rr && !pre_empty) begin m_dout = q.pop_front(); m_rv = 1; end
      if (w && !pre_full) q.push_back(d);
    end
    n = q.size();
    check("std_level", 32'(lvl_s),   32'(n));
    check("std_full",  32'(full_s),  32'(n == 16));
    check("std_empty", 32'(empty_s), 32'(n == 0));
    check("std_afull", 32'(af_s),    32'(n >= 12));
    check("std_aempty",32'(ae_s),    32'(n <= 2));
    check("std_ovf",   32'(ovf_s),   32'(m_ovf));
    check("std_unf",   32'(unf_s),   32'(m_unf));
    check("std_rvalid",32'(rv_s),    32'(m_rv));
    check("std_dout",  32'(dout_s),  32'(m_dout));
    check("fw_level",  32'(lvl_f),   32'(n));
    check("fw_full",   32'(full_f),  32'(n == 16));
    check("fw_empty",  32'(empty_f), 32'(n == 0));
    check("fw_afull",  32'(af_f),    32'(n >= 12));
    check("fw_aempty", 32'(ae_f),    32'(n <= 2));
    check("fw_ovf",    32'(ovf_f),   32'(m_ovf));
    check("fw_unf",    32'(unf_f),   32'(m_unf));
    check("fw_rvalid", 32'(rv_f),    32'(n != 0));
    if (n != 0) check("fw_dout", 32'(dout_f), 32'(q[0]));
  endtask

  task automatic wr1(input logic [7:0] d); cyc(0, 1, d, 0, 0); endtask
  task automatic rd1();                    cyc(0, 0, 8'h00, 1, 0); endtask
  task automatic clr1();                   cyc(0, 0, 8'h00, 0, 1); endtask

  initial begin
    int written, lvl, loops;
    bit w, r;
    rst = 1; wr = 0; rd = 0; flag_clr = 0; din = 8'h00;

    // Reset state
    cyc(1, 0, 8'h00, 0, 0);
    cyc(1, 0, 8'h00, 0, 0);

    // Mid-stream reset discards stored words
    for (int i = 0; i < 5; i++) wr1(8'(8'h30 + i));
    cyc(1, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);

    // Fill 0x01..0x10, overflow, clear, drain, underflow, clear
    for (int i = 1; i <= 16; i++) wr1(8'(i));
    wr1(8'hEE);
    clr1();
    for (int i = 0; i < 16; i++) rd1();
    rd1();
    clr1();

    // Simultaneous wr&rd at empty, then at full, then at level 7
    cyc(0, 1, 8'h55, 1, 0);
    rd1();
    clr1();
    for (int i = 0; i < 16; i++) wr1(8'(8'h60 + i));
    cyc(0, 1, 8'h77, 1, 0);
    for (int i = 0; i < 15; i++) rd1();
    clr1();
    for (int i = 0; i < 7; i++) wr1(8'(8'hC0 + i));
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'(8'h80 + i), 1, 0);
    for (int i = 0; i < 7; i++) rd1();

    // Wrap: 40 words streamed with level kept in 3..10
    written = 0;
    loops = 0;
    while ((written < 40 || q.size() > 0) && loops < 1000) begin
      lvl = q.size();
      w = (written < 40) && (lvl < 3 || (lvl < 10 && ($urandom % 2 == 0)));
      r = (lvl >= 10) || (lvl > 3 && ($urandom % 2 == 0)) || (written >= 40 && lvl > 0);
      cyc(0, w, 8'($urandom), r, 0);
      if (w) written++;
      loops++;
    end
    check("wrap_done", 32'(q.size()), 32'd0);

    // FWFT head visibility right after the write edge
    cyc(1, 0, 8'h00, 0, 0);
    wr1(8'hA5);
    check("fwft_a5", 32'(dout_f), 32'h0000_00A5);
    rd1();
    check("fwft_empty", 32'(empty_f), 32'd1);

    // Random traffic with occasional clears and resets
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom % 97) == 0, ($urandom % 2) == 0, 8'($urandom),
          ($urandom % 2) == 0, ($urandom % 16) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
